// File: rtl/ami_w.sv
// -----------------------------------------------------------------------------
// ami_w : AXI4 master write engine
//
// Takes write commands and a beat stream from user logic and drives them onto
// an AXI4 master write port (AW / W / B channels). Every command is screened
// before it reaches the bus. An illegal command is consumed and reported with a
// one-cycle usr_wcmd_err pulse, and nothing is issued for it. Legal commands are
// registered into the AW stage. Their burst lengths are queued so that the W
// engine can frame the user's beat stream independently of the AW handshake.
// The number of outstanding bursts (AW accepted, B not yet seen) is bounded by
// AMI_OD.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   usr_wcmd_valid / usr_wcmd_ready command handshake
//   usr_wcmd_id/addr/len/size/burst command fields
//   usr_wcmd_err                    one-cycle pulse: last accepted command was illegal
//   usr_wdata, usr_wstrb            beat payload
//   usr_wvalid / usr_wready         beat handshake
//   usr_bid, usr_bresp              write response
//   usr_bvalid / usr_bready         response handshake
//   AW*, W*, B*                     AXI4 master write channels
// -----------------------------------------------------------------------------
module ami_w #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 40,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AXI_BRESPW = 2,
  parameter int AMI_OD     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  // user command
  input  logic                    usr_wcmd_valid,
  output logic                    usr_wcmd_ready,
  input  logic [AXI_IW-1:0]       usr_wcmd_id,
  input  logic [AXI_AW-1:0]       usr_wcmd_addr,
  input  logic [AXI_LW-1:0]       usr_wcmd_len,
  input  logic [AXI_SW-1:0]       usr_wcmd_size,
  input  logic [AXI_BURSTW-1:0]   usr_wcmd_burst,
  output logic                    usr_wcmd_err,

  // user beat data
  input  logic [AXI_DW-1:0]       usr_wdata,
  input  logic [AXI_DW/8-1:0]     usr_wstrb,
  input  logic                    usr_wvalid,
  output logic                    usr_wready,

  // user response
  output logic [AXI_IW-1:0]       usr_bid,
  output logic [AXI_BRESPW-1:0]   usr_bresp,
  output logic                    usr_bvalid,
  input  logic                    usr_bready,

  // AXI4 write address channel
  output logic [AXI_IW-1:0]       AWID,
  output logic [AXI_AW-1:0]       AWADDR,
  output logic [AXI_LW-1:0]       AWLEN,
  output logic [AXI_SW-1:0]       AWSIZE,
  output logic [AXI_BURSTW-1:0]   AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,

  // AXI4 write data channel
  output logic [AXI_DW-1:0]       WDATA,
  output logic [AXI_DW/8-1:0]     WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,

  // AXI4 write response channel
  input  logic [AXI_IW-1:0]       BID,
  input  logic [AXI_BRESPW-1:0]   BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int OCW = $clog2(AMI_OD + 1);  // outstanding / queue-count width
  localparam int QPW = $clog2(AMI_OD);      // queue pointer width

  localparam logic [AXI_SW-1:0]     MAX_SIZE    = AXI_SW'($clog2(AXI_DW / 8));
  localparam logic [AXI_BURSTW-1:0] BURST_FIXED = AXI_BURSTW'(0);
  localparam logic [AXI_BURSTW-1:0] BURST_WRAP  = AXI_BURSTW'(2);
  localparam logic [AXI_BURSTW-1:0] BURST_RSVD  = AXI_BURSTW'(3);
  localparam logic [OCW-1:0]        OD_LIMIT    = OCW'(AMI_OD);

  typedef enum logic {
    W_IDLE,
    W_DATA
  } w_state_t;

  // ---------------------------------------------------------------------------
  // Command screening (purely combinational on the command inputs)
  // ---------------------------------------------------------------------------
  logic [AXI_AW-1:0] w_size_mask;
  logic [AXI_AW-1:0] w_aligned;
  logic [AXI_AW-1:0] w_span;
  logic [AXI_AW-1:0] w_end;
  logic              w_cross_4k;
  logic              w_wrap_len_ok;
  logic              w_cmd_err;

  assign w_size_mask = (AXI_AW'(1) << usr_wcmd_size) - AXI_AW'(1);
  assign w_aligned   = usr_wcmd_addr & ~w_size_mask;
  assign w_span      = (AXI_AW'(usr_wcmd_len) + AXI_AW'(1)) << usr_wcmd_size;
  assign w_end       = w_aligned + w_span - AXI_AW'(1);
  // An INCR burst is legal only if its last byte sits on the same 4 KB page
  // as the start address; comparing page numbers covers wrap past the top too.
  assign w_cross_4k  = (w_end >> 12) != (usr_wcmd_addr >> 12);

  assign w_wrap_len_ok = (usr_wcmd_len == AXI_LW'(1)) || (usr_wcmd_len == AXI_LW'(3)) ||
                         (usr_wcmd_len == AXI_LW'(7)) || (usr_wcmd_len == AXI_LW'(15));

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so that no
    // path through the block can leave it unassigned and infer a latch.
    w_cmd_err = 1'b0;
    if (usr_wcmd_size > MAX_SIZE) begin
      w_cmd_err = 1'b1;
    end else begin
      case (usr_wcmd_burst)
        BURST_FIXED: w_cmd_err = usr_wcmd_len > AXI_LW'(15);
        BURST_WRAP:  w_cmd_err = !w_wrap_len_ok || ((usr_wcmd_addr & w_size_mask) != '0);
        BURST_RSVD:  w_cmd_err = 1'b1;
        default:     w_cmd_err = w_cross_4k;   // INCR
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic [OCW-1:0] r_outstanding;
  logic [OCW-1:0] r_q_cnt;
  logic           r_awvalid;
  w_state_t       r_wstate;

  logic w_accept;
  logic w_accept_ok;
  logic w_b_hs;
  logic w_pop;
  logic w_w_hs;
  logic w_wlast;

  // One command may sit in the AW stage at a time; the next one is taken in
  // the cycle after AWVALID drops.
  assign usr_wcmd_ready = !r_awvalid && (r_outstanding < OD_LIMIT) && (r_q_cnt != OD_LIMIT);
  assign w_accept       = usr_wcmd_valid && usr_wcmd_ready;
  assign w_accept_ok    = w_accept && !w_cmd_err;
  assign w_b_hs         = BVALID && usr_bready;
  assign w_pop          = (r_wstate == W_IDLE) && (r_q_cnt != '0);

  // ---------------------------------------------------------------------------
  // AW stage: fields captured on acceptance, held until AWREADY
  // ---------------------------------------------------------------------------
  logic [AXI_IW-1:0]     r_awid;
  logic [AXI_AW-1:0]     r_awaddr;
  logic [AXI_LW-1:0]     r_awlen;
  logic [AXI_SW-1:0]     r_awsize;
  logic [AXI_BURSTW-1:0] r_awburst;
  logic                  r_cmd_err;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awvalid <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_accept && w_cmd_err;
      if (w_accept_ok) begin
        r_awvalid <= 1'b1;
        r_awid    <= usr_wcmd_id;
        r_awaddr  <= usr_wcmd_addr;
        r_awlen   <= usr_wcmd_len;
        r_awsize  <= usr_wcmd_size;
        r_awburst <= usr_wcmd_burst;
      end else if (r_awvalid && AWREADY) begin
        r_awvalid <= 1'b0;
      end
    end
  end

  assign AWVALID      = r_awvalid;
  assign AWID         = r_awid;
  assign AWADDR       = r_awaddr;
  assign AWLEN        = r_awlen;
  assign AWSIZE       = r_awsize;
  assign AWBURST      = r_awburst;
  assign usr_wcmd_err = r_cmd_err;

  // ---------------------------------------------------------------------------
  // Length queue: burst lengths waiting for the W engine
  // ---------------------------------------------------------------------------
  logic [AXI_LW-1:0] r_q_mem [AMI_OD];
  logic [QPW-1:0]    r_q_wr;
  logic [QPW-1:0]    r_q_rd;

  // NOTE: the storage array carries no reset; r_q_cnt alone decides which
  // entries are valid, so clearing the contents would buy nothing.
  always_ff @(posedge clk) begin
    if (w_accept_ok) begin
      r_q_mem[r_q_wr] <= usr_wcmd_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_accept_ok) r_q_wr <= r_q_wr + QPW'(1);
      if (w_pop)       r_q_rd <= r_q_rd + QPW'(1);
      case ({w_accept_ok, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + OCW'(1);
        2'b01:   r_q_cnt <= r_q_cnt - OCW'(1);
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // W engine: frames the user beat stream into bursts of the queued lengths
  // ---------------------------------------------------------------------------
  logic [AXI_LW-1:0] r_wlen;
  logic [AXI_LW-1:0] r_wbeat;

  assign w_wlast = (r_wstate == W_DATA) && (r_wbeat == r_wlen);
  assign w_w_hs  = (r_wstate == W_DATA) && usr_wvalid && WREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_wlen   <= '0;
      r_wbeat  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_pop) begin
            r_wlen   <= r_q_mem[r_q_rd];
            r_wbeat  <= '0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (w_wlast) r_wstate <= W_IDLE;
            else         r_wbeat  <= r_wbeat + AXI_LW'(1);
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign WVALID     = (r_wstate == W_DATA) && usr_wvalid;
  assign usr_wready = (r_wstate == W_DATA) && WREADY;
  assign WLAST      = w_wlast;
  assign WDATA      = usr_wdata;
  assign WSTRB      = usr_wstrb;

  // ---------------------------------------------------------------------------
  // B path and outstanding-burst accounting
  // ---------------------------------------------------------------------------
  assign usr_bvalid = BVALID;
  assign usr_bid    = BID;
  assign usr_bresp  = BRESP;
  assign BREADY     = usr_bready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      // A response with nothing outstanding is a slave protocol violation;
      // it is absorbed so the counter cannot wrap.
      case ({w_accept_ok, w_b_hs && (r_outstanding != '0)})
        2'b10:   r_outstanding <= r_outstanding + OCW'(1);
        2'b01:   r_outstanding <= r_outstanding - OCW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ami_w.sv
// -----------------------------------------------------------------------------
// tb_ami_w : self-checking bench for ami_w
//
// A table of command vectors (legal and illegal) is applied in a loop, followed
// by randomized commands whose legality is predicted by a page/beat arithmetic
// model, and hand-written sequences for the AW back-pressure, outstanding limit,
// simultaneous accept/response and mid-burst reset cases.
// -----------------------------------------------------------------------------
module tb_ami_w;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         usr_wcmd_valid;
  logic         usr_wcmd_ready;
  logic [7:0]   usr_wcmd_id;
  logic [39:0]  usr_wcmd_addr;
  logic [7:0]   usr_wcmd_len;
  logic [2:0]   usr_wcmd_size;
  logic [1:0]   usr_wcmd_burst;
  logic         usr_wcmd_err;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wvalid;
  logic         usr_wready;
  logic [7:0]   usr_bid;
  logic [1:0]   usr_bresp;
  logic         usr_bvalid;
  logic         usr_bready;
  logic [7:0]   AWID;
  logic [39:0]  AWADDR;
  logic [7:0]   AWLEN;
  logic [2:0]   AWSIZE;
  logic [1:0]   AWBURST;
  logic         AWVALID;
  logic         AWREADY;
  logic [127:0] WDATA;
  logic [15:0]  WSTRB;
  logic         WLAST;
  logic         WVALID;
  logic         WREADY;
  logic [7:0]   BID;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;

  ami_w dut (
    .clk(clk), .rst_n(rst_n),
    .usr_wcmd_valid(usr_wcmd_valid), .usr_wcmd_ready(usr_wcmd_ready),
    .usr_wcmd_id(usr_wcmd_id), .usr_wcmd_addr(usr_wcmd_addr), .usr_wcmd_len(usr_wcmd_len),
    .usr_wcmd_size(usr_wcmd_size), .usr_wcmd_burst(usr_wcmd_burst), .usr_wcmd_err(usr_wcmd_err),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid), .usr_bready(usr_bready),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legality of a command, from burst rules expressed in bytes and pages.
  function automatic bit model_err(logic [39:0] addr, logic [7:0] len, logic [2:0] size,
                                   logic [1:0] burst);
    longint unsigned nbytes, a, first, last, beats;
    if (size > 3'd4) return 1'b1;
    if (burst == 2'd3) return 1'b1;
    beats  = longint'(len) + 1;
    nbytes = longint'(1) << size;
    a      = longint'(addr);
    if (burst == 2'd0) return beats > 16;
    if (burst == 2'd2) return !(beats == 2 || beats == 4 || beats == 8 || beats == 16) ||
                              (a % nbytes != 0);
    first = a - (a % nbytes);
    last  = first + beats * nbytes - 1;
    return (last / 4096) != (a / 4096);
  endfunction

  // Present a command and hold it until the accepting edge has passed.
  task automatic send_cmd(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    while (!usr_wcmd_ready && n < 200) begin
      step();
      n++;
    end
    if (!usr_wcmd_ready) check("cmd_ready_timeout", 1'b0, 1'b1);
    usr_wcmd_valid = 1'b1;
    usr_wcmd_id    = id;
    usr_wcmd_addr  = addr;
    usr_wcmd_len   = len;
    usr_wcmd_size  = size;
    usr_wcmd_burst = burst;
    step();
    usr_wcmd_valid = 1'b0;
  endtask

  task automatic aw_handshake();
    AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
  endtask

  // Stream nbeats beats; optionally toggle WREADY every cycle.
  task automatic send_beats(input int nbeats, input bit toggle, input string tag);
    int hs = 0;
    int cyc = 0;
    int bad = 0;
    bit wr = 1'b1;
    usr_wvalid = 1'b1;
    while (hs < nbeats && cyc < 2000) begin
      WREADY    = toggle ? wr : 1'b1;
      wr        = ~wr;
      usr_wdata = {$urandom, $urandom, $urandom, $urandom};
      usr_wstrb = 16'($urandom);
      #1;
      if (WVALID && WREADY) begin
        if (WLAST !== (hs == nbeats - 1)) bad++;
        if (WDATA !== usr_wdata || WSTRB !== usr_wstrb || usr_wready !== 1'b1) bad++;
        hs++;
      end else if (WLAST && !WVALID && hs == 0 && cyc > 2) begin
        bad++;
      end
      step();
      cyc++;
    end
    usr_wvalid = 1'b0;
    WREADY     = 1'b0;
    check({tag, " w_beats"}, 128'(hs), 128'(nbeats));
    check({tag, " wlast_pos"}, 128'(bad), 128'd0);
  endtask

  task automatic do_b(input logic [7:0] id, input logic [1:0] resp, input string tag);
    BVALID     = 1'b1;
    BID        = id;
    BRESP      = resp;
    usr_bready = 1'b1;
    #1;
    check({tag, " b_path"}, {usr_bvalid, usr_bid, usr_bresp, BREADY}, {1'b1, id, resp, 1'b1});
    step();
    BVALID     = 1'b0;
    usr_bready = 1'b0;
  endtask

  // Apply one command vector end to end and check its fate.
  task automatic run_vec(input vec_t v, input logic [7:0] id, input string tag);
    logic [1:0] resp;
    send_cmd(id, v.addr, v.len, v.size, v.burst);
    #1;
    check({tag, " err"}, usr_wcmd_err, v.exp_err);
    check({tag, " awvalid"}, AWVALID, !v.exp_err);
    if (!v.exp_err) begin
      check({tag, " aw_fields"}, {AWID, AWADDR, AWLEN, AWSIZE, AWBURST},
            {id, v.addr, v.len, v.size, v.burst});
      aw_handshake();
      send_beats(int'(v.len) + 1, 1'b0, tag);
      resp = 2'($urandom);
      do_b(id, resp, tag);
    end else begin
      step();
      check({tag, " err_once"}, usr_wcmd_err, 1'b0);
    end
    check({tag, " outstanding"}, dut.r_outstanding, 3'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int bad;
    vec_t rv;
    logic [7:0] len_pick[8];

    usr_wcmd_valid = 1'b0; usr_wcmd_id = '0; usr_wcmd_addr = '0; usr_wcmd_len = '0;
    usr_wcmd_size = '0; usr_wcmd_burst = '0; usr_wdata = '0; usr_wstrb = '0;
    usr_wvalid = 1'b0; usr_bready = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    BID = '0; BRESP = '0; BVALID = 1'b0;

    vecs[0]  = '{40'h0FF0,     8'd1,  3'd4, 2'd1, 1'b1};  // crosses 4 KB
    vecs[1]  = '{40'h1000,     8'd0,  3'd5, 2'd1, 1'b1};  // size too large
    vecs[2]  = '{40'h1000,     8'd0,  3'd2, 2'd3, 1'b1};  // reserved burst
    vecs[3]  = '{40'h1000,     8'd2,  3'd2, 2'd2, 1'b1};  // WRAP len 2
    vecs[4]  = '{40'h1004,     8'd3,  3'd3, 2'd2, 1'b1};  // WRAP misaligned
    vecs[5]  = '{40'h1000,     8'd3,  3'd4, 2'd2, 1'b0};  // WRAP legal
    vecs[6]  = '{40'h1000,     8'd16, 3'd2, 2'd0, 1'b1};  // FIXED len 16
    vecs[7]  = '{40'h1000,     8'd15, 3'd2, 2'd0, 1'b0};  // FIXED len 15
    vecs[8]  = '{40'h0F00,     8'd15, 3'd4, 2'd1, 1'b0};  // ends exactly at 0xFFF
    vecs[9]  = '{40'h0F10,     8'd15, 3'd4, 2'd1, 1'b1};  // ends at 0x100F
    vecs[10] = '{40'h0FFF,     8'd0,  3'd4, 2'd1, 1'b0};  // unaligned, stays in page
    vecs[11] = '{40'hAB_0000_0F80, 8'd7, 3'd4, 2'd1, 1'b0};

    // ---- reset state -------------------------------------------------------
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {AWVALID, WVALID, WLAST, usr_wready, usr_wcmd_err},
          5'b00000);
    check("reset aw_fields", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, '0);
    check("reset outstanding", dut.r_outstanding, 3'd0);
    rst_n = 1'b1;
    step();
    check("reset cmd_ready", usr_wcmd_ready, 1'b1);

    // ---- single-beat write --------------------------------------------------
    send_cmd(8'h05, 40'h1000, 8'd0, 3'd4, 2'd1);
    #1;
    check("single awvalid", AWVALID, 1'b1);
    check("single aw_fields", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST},
          {8'h05, 40'h1000, 8'd0, 3'd4, 2'd1});
    check("single cmd_ready_busy", usr_wcmd_ready, 1'b0);
    check("single outstanding", dut.r_outstanding, 3'd1);
    aw_handshake();
    check("single aw_drop", AWVALID, 1'b0);
    send_beats(1, 1'b0, "single");
    do_b(8'h05, 2'd0, "single");
    check("single outstanding_done", dut.r_outstanding, 3'd0);

    // ---- 16-beat INCR, AWREADY delayed, WREADY toggling ---------------------
    send_cmd(8'h21, 40'h2000, 8'd15, 3'd4, 2'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (AWVALID !== 1'b1 || AWADDR !== 40'h2000 || AWLEN !== 8'd15 || AWID !== 8'h21 ||
          usr_wcmd_ready !== 1'b0) bad++;
      step();
    end
    check("burst16 aw_stable", 128'(bad), 128'd0);
    aw_handshake();
    check("burst16 aw_drop", AWVALID, 1'b0);
    send_beats(16, 1'b1, "burst16");
    do_b(8'h21, 2'd2, "burst16");

    // ---- table-driven command screening --------------------------------------
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 8'(i + 8'h40), $sformatf("vec%0d", i));
    end

    // ---- outstanding limit ---------------------------------------------------
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'(i), 40'h4000 + 40'(i * 16), 8'd0, 3'd4, 2'd1);
      aw_handshake();
      send_beats(1, 1'b0, "od");
    end
    #1;
    check("od full_ready", usr_wcmd_ready, 1'b0);
    check("od full_count", dut.r_outstanding, 3'd4);
    usr_wcmd_valid = 1'b1;
    usr_wcmd_burst = 2'd1; usr_wcmd_size = 3'd4; usr_wcmd_len = 8'd0;
    step(); step();
    usr_wcmd_valid = 1'b0;
    #1;
    check("od blocked_awvalid", AWVALID, 1'b0);
    do_b(8'd0, 2'd0, "od");
    check("od reopen_ready", usr_wcmd_ready, 1'b1);
    send_cmd(8'd4, 40'h4040, 8'd0, 3'd4, 2'd1);
    aw_handshake();
    send_beats(1, 1'b0, "od5");
    do_b(8'd1, 2'd0, "od");
    #1;
    check("od count3", dut.r_outstanding, 3'd3);
    // Accept and response in the same cycle.
    BVALID = 1'b1; BID = 8'd2; BRESP = 2'd0; usr_bready = 1'b1;
    send_cmd(8'd5, 40'h4050, 8'd0, 3'd4, 2'd1);
    BVALID = 1'b0; usr_bready = 1'b0;
    #1;
    check("od simult_count", dut.r_outstanding, 3'd3);
    aw_handshake();
    send_beats(1, 1'b0, "od6");
    do_b(8'd3, 2'd0, "od");
    do_b(8'd4, 2'd0, "od");
    do_b(8'd5, 2'd0, "od");
    #1;
    check("od drained", dut.r_outstanding, 3'd0);
    do_b(8'd9, 2'd0, "od_extra");
    #1;
    check("od no_underflow", dut.r_outstanding, 3'd0);

    // ---- randomized commands against the legality model ---------------------
    len_pick = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd31};
    for (int i = 0; i < 60; i++) begin
      rv.addr  = {8'($urandom), $urandom};
      if ($urandom_range(0, 1) == 0) rv.addr[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
      rv.len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 63))
                                             : len_pick[$urandom_range(0, 7)];
      rv.size  = 3'($urandom_range(0, 5));
      rv.burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) rv.addr = rv.addr & ~((40'd1 << rv.size) - 40'd1);
      rv.exp_err = model_err(rv.addr, rv.len, rv.size, rv.burst);
      run_vec(rv, 8'($urandom), $sformatf("rnd%0d", i));
    end

    // ---- reset asserted mid-burst -------------------------------------------
    send_cmd(8'h33, 40'h6000, 8'd7, 3'd4, 2'd1);
    aw_handshake();
    usr_wvalid = 1'b1;
    WREADY     = 1'b1;
    step(); step(); step();
    send_cmd(8'h34, 40'h7000, 8'd0, 3'd4, 2'd1);
    #1;
    check("rst pre_state", {AWVALID, WVALID, usr_wready}, 3'b111);
    check("rst pre_outstanding", dut.r_outstanding, 3'd2);
    rst_n = 1'b0;
    #1;
    check("rst immediate", {AWVALID, WVALID, usr_wready, WLAST}, 4'b0000);
    check("rst outstanding", dut.r_outstanding, 3'd0);
    step();
    usr_wvalid = 1'b0;
    WREADY     = 1'b0;
    rst_n      = 1'b1;
    step();
    check("rst recover_ready", usr_wcmd_ready, 1'b1);
    run_vec(vecs[10], 8'h77, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
